// File: rtl/beep_driver.sv
// beep_driver: turns a one-cycle start request into a timed buzzer waveform
// of `count` beeps, each ON_CYCLES long and separated by OFF_CYCLES gaps.
// All outputs are registered so the pin never glitches.
module beep_driver #(
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       stop,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rem_q, rem_d;
  logic          buzzer_d, busy_d, done_d;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      buzzer  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      buzzer  <= buzzer_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next-state, counter update and next output values
  // Outputs are derived from the next state so they register on the same
  // edge as the state transition (start -> buzzer high from that edge).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (count != 4'd0) && !stop) begin
          state_d = S_ON;
          timer_d = ON_LOAD;
          rem_d   = count;
        end
      end

      S_ON: begin
        if (stop) begin
          state_d = S_IDLE;
          timer_d = '0;
          rem_d   = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (rem_q > 4'd1) begin
          state_d = S_OFF;
          timer_d = OFF_LOAD;
          rem_d   = rem_q - 4'd1;
        end else begin
          state_d = S_IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
        end
      end

      S_OFF: begin
        if (stop) begin
          state_d = S_IDLE;
          timer_d = '0;
          rem_d   = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = S_ON;
          timer_d = ON_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        rem_d   = '0;
      end
    endcase

    buzzer_d = (state_d == S_ON);
    busy_d   = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_beep_driver.sv
// Self-checking bench for beep_driver: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// schedule-based reference model.
module tb_beep_driver;

  localparam int unsigned ON  = 3;
  localparam int unsigned OFF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic       stop = 1'b0;
  logic       buzzer, busy, done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  beep_driver #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .count  (count),
    .stop   (stop),
    .buzzer (buzzer),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is a window of total cycles after the start
  // edge; within it, position k is a beep when k mod (ON+OFF) < ON.
  bit          m_active = 1'b0;
  bit          m_done   = 1'b0;
  int unsigned m_k      = 0;
  int unsigned m_total  = 0;
  bit          cmp_en   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
    end else if (m_active) begin
      m_done = 1'b0;
      if (stop) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        if (m_k == m_total) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (start && count != 4'd0 && !stop) begin
        m_active = 1'b1;
        m_k      = 0;
        m_total  = int'(count) * ON + (int'(count) - 1) * OFF;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (cmp_en && !rst) begin
      chk("model_busy",   int'(busy),   int'(m_active));
      chk("model_buzzer", int'(buzzer), int'(m_active && ((m_k % (ON + OFF)) < ON)));
      chk("model_done",   int'(done),   int'(m_done));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Runs a count=2 sequence for edges 0..9, optionally injecting a start
  // with count=3 at edge 4; records outputs after each edge.
  task automatic run_basic(input bit inject, output logic [9:0] bz,
                           output logic [9:0] bs, output logic [9:0] dn);
    start = 1'b1;
    count = 4'd2;
    for (int e = 0; e < 10; e++) begin
      edge1();
      bz[e] = buzzer;
      bs[e] = busy;
      dn[e] = done;
      start = 1'b0;
      if (inject && e == 3) begin
        start = 1'b1;
        count = 4'd3;
      end
    end
  endtask

  logic [9:0] bz_a, bs_a, dn_a, bz_b, bs_b, dn_b;
  bit         saw;

  initial begin
    // Reset state
    #2;
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_busy",   int'(busy),   0);
    chk("reset_done",   int'(done),   0);
    edge1();
    edge1();
    rst = 1'b0;
    cmp_en = 1'b1;
    edge1();

    // Basic sequence with literal waveform
    run_basic(1'b0, bz_a, bs_a, dn_a);
    chk("basic_buzzer", int'(bz_a), int'(10'b00_1110_0111));
    chk("basic_busy",   int'(bs_a), int'(10'b00_1111_1111));
    chk("basic_done",   int'(dn_a), int'(10'b01_0000_0000));
    edge1();

    // Start during a run is ignored
    run_basic(1'b1, bz_b, bs_b, dn_b);
    chk("inject_buzzer", int'(bz_b), int'(10'b00_1110_0111));
    chk("inject_busy",   int'(bs_b), int'(10'b00_1111_1111));
    chk("inject_done",   int'(dn_b), int'(10'b01_0000_0000));
    edge1();

    // Single beep: high 3 cycles, done at edge 3, no gap
    start = 1'b1;
    count = 4'd1;
    for (int e = 0; e < 5; e++) begin
      edge1();
      start = 1'b0;
      chk("single_buzzer", int'(buzzer), int'(e < 3));
      chk("single_done",   int'(done),   int'(e == 3));
      chk("single_busy",   int'(busy),   int'(e < 3));
    end

    // Start with count=0 is ignored
    start = 1'b1;
    count = 4'd0;
    for (int e = 0; e < 4; e++) begin
      edge1();
      start = 1'b0;
      chk("zero_busy", int'(busy), 0);
      chk("zero_done", int'(done), 0);
    end

    // Abort during OFF at edge 4
    start = 1'b1;
    count = 4'd3;
    saw = 1'b0;
    for (int e = 0; e < 14; e++) begin
      edge1();
      start = 1'b0;
      stop = 1'b0;
      if (done) saw = 1'b1;
      if (e == 3) begin
        chk("abort_pre_off", int'(buzzer), 0);
        stop = 1'b1;
      end
      if (e == 4) begin
        chk("abort_buzzer", int'(buzzer), 0);
        chk("abort_busy",   int'(busy),   0);
        chk("abort_done",   int'(done),   0);
      end
    end
    chk("abort_no_done", int'(saw), 0);

    // Start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    count = 4'd2;
    edge1();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", int'(busy), 0);
    edge1();
    chk("startstop_busy2", int'(busy), 0);

    // Back-to-back: new start at the edge after done
    start = 1'b1;
    count = 4'd1;
    for (int e = 0; e < 8; e++) begin
      edge1();
      start = 1'b0;
      if (e == 3) begin
        chk("b2b_done", int'(done), 1);
        start = 1'b1;
        count = 4'd1;
      end
      if (e == 4) chk("b2b_buzzer", int'(buzzer), 1);
      if (e == 7) chk("b2b_done2", int'(done), 1);
    end
    edge1();

    // Reset mid-beep: asynchronous, between edges 1 and 2
    start = 1'b1;
    count = 4'd2;
    edge1();
    start = 1'b0;
    edge1();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_buzzer", int'(buzzer), 0);
    chk("rst_async_busy",   int'(busy),   0);
    chk("rst_async_done",   int'(done),   0);
    edge1();
    #3;
    rst = 1'b0;
    for (int e = 0; e < 6; e++) begin
      edge1();
      chk("rst_stay_idle", int'(busy), 0);
    end

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      edge1();
      start = ($urandom_range(0, 3) == 0);
      count = 4'($urandom_range(0, 15));
      stop  = ($urandom_range(0, 24) == 0);
    end
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 80; i++) edge1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beep_driver.md
# beep_driver

Output-side counterpart to the button input synchronizer: where the synchronizer turns an asynchronous button into a clean one-cycle event, this block turns a one-cycle internal event into a timed, glitch-free pin waveform. On a start pulse it drives the buzzer/indicator pin with a programmable number of beeps, each a fixed ON interval separated by a fixed OFF interval. The washing-machine controller uses it for cycle-done and error alerts. All outputs are registered, so the pin never glitches.

## Interface
- ON_CYCLES, default 25_000_000, length of one beep in clk cycles; must be ≥1.
- OFF_CYCLES, default 25_000_000, gap between beeps in clk cycles; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, already synchronous to clk.
- count  in  4  number of beeps, sampled with start; 0 means no beeps.
- stop  in  1  synchronous abort, level-sensitive.
- buzzer  out  1  beep waveform to the pin, registered.
- busy  out  1  high while a sequence is active, registered.
- done  out  1  one-cycle pulse when a sequence completes normally, registered.

## Operation
- State machine: IDLE, ON, OFF.
- Internal registers:
  - timer, width clog2(max(ON_CYCLES, OFF_CYCLES)).
  - remaining, 4 bits.
- IDLE:
  - start=1, count≠0, stop=0 → latch remaining=count, load timer=ON_CYCLES-1, go ON.
  - start with count=0 → ignored: stay IDLE, no busy, no done.
- ON: buzzer=1 and busy=1.
  - Timer counts down to 0.
  - At 0 with remaining>1 → decrement remaining, load timer=OFF_CYCLES-1, go OFF.
  - At 0 with remaining=1 → go IDLE and assert done for that one cycle.
- OFF: buzzer=0, busy=1.
  - At timer=0 → load ON_CYCLES-1, go ON.
- No OFF interval follows the last beep.
- start while busy is ignored; the running sequence is not extended or restarted.
- stop=1 in ON or OFF → go IDLE at the next edge with buzzer=0, busy=0, done=0.
- stop in IDLE has no effect. stop and start together in IDLE: stop wins, nothing starts.
- done is never asserted on an abort.
- A new start is accepted in the cycle after a sequence ends, whether it ended normally or by abort.

## Timing
- rst asserted (asynchronous, any time, including mid-beep):
  - buzzer=0, busy=0, done=0, state=IDLE, timer=0, remaining=0.
  - Takes effect immediately, without waiting for a clock edge.
- Start latency: start sampled at edge E → buzzer=1 and busy=1 from edge E onward.
- Each beep holds buzzer high for exactly ON_CYCLES cycles.
- Each gap holds buzzer low for exactly OFF_CYCLES cycles.
- Total busy duration = count·ON_CYCLES + (count-1)·OFF_CYCLES cycles.
- done rises on the same edge where busy and buzzer fall, and lasts exactly 1 cycle.
- Abort latency: stop sampled at edge E → all outputs 0 after edge E.
- count=15 with maximal parameters must not overflow timer or remaining. timer never wraps; it is always reloaded at 0.

## Test plan
- Reset mid-beep:
  - Stimulus: ON=3, OFF=2, count=2, start at edge 0; rst raised asynchronously between edges 1 and 2.
  - Required: buzzer, busy, done drop to 0 immediately; after rst release, stay idle until a new start.
- Basic sequence:
  - Stimulus: ON=3, OFF=2, count=2, start at edge 0.
  - Required:
    - buzzer=1 after edges 0–2, 0 after edges 3–4, 1 after edges 5–7.
    - At edge 8: buzzer=0, busy=0, done=1.
    - done=0 after edge 9.
- Single beep:
  - Stimulus: ON=3, count=1, start at edge 0.
  - Required: buzzer high 3 cycles; done at edge 3; no OFF state is entered.
- Ignored requests:
  - Stimulus 1: start with count=0. Required: no output change.
  - Stimulus 2: start with count=3 at edge 4 during a count=2 run. Required: waveform identical to the basic sequence.
- Abort:
  - Stimulus: ON=3, OFF=2, count=3; stop at edge 4 (during OFF).
  - Required: all outputs 0 after edge 4; no done.
  - Stimulus: start and stop together in IDLE. Required: nothing starts.
- Back-to-back:
  - Stimulus: new start at the edge after done (count=1).
  - Required: buzzer rises at that edge; no lost or merged beeps.
